// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver, 8 data bits, optional parity, 1 stop bit
module uart_rx #(
    parameter int    CLK_FREQ   = 50000000,
    parameter int    BAUD_RATE  = 115200,
    parameter int    OS_RATE    = 16,
    parameter string PARITY_BIT = "none"
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       UART_RXD,
    output logic [7:0] DOUT,
    output logic       DOUT_VLD,
    output logic       FRAME_ERROR,
    output logic       PARITY_ERROR
);

    localparam int OS_CLK_DIV = (CLK_FREQ + (OS_RATE * BAUD_RATE) / 2) / (OS_RATE * BAUD_RATE);
    localparam int DIV_W      = (OS_CLK_DIV > 1) ? $clog2(OS_CLK_DIV) : 1;
    localparam int BIT_W      = $clog2(OS_RATE);
    localparam bit PAR_EN     = (PARITY_BIT != "none");
    localparam bit PAR_ODD    = (PARITY_BIT == "odd");

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [1:0]       sync_q;
    logic             rxd_d_q;
    logic             rxd_s;
    logic             fall_edge;

    logic [DIV_W-1:0] os_cnt_q;
    logic             os_tick;
    logic [BIT_W-1:0] bit_cnt_q;
    logic             sample;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [7:0]       dout_q, dout_d;
    logic             vld_q, vld_d;
    logic             fe_q, fe_d;
    logic             pe_q, pe_d;
    logic             par_mismatch;

    assign rxd_s     = sync_q[1];
    assign fall_edge = rxd_d_q & ~rxd_s;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q  <= 2'b11;
            rxd_d_q <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], UART_RXD};
            rxd_d_q <= rxd_s;
        end
    end

    // Free-running divider: sample phase error stays within one os_tick.
    assign os_tick = (os_cnt_q == DIV_W'(OS_CLK_DIV - 1));

    always_ff @(posedge CLK) begin
        if (RST || os_tick) begin
            os_cnt_q <= '0;
        end else begin
            os_cnt_q <= os_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || state_q == S_IDLE) begin
            bit_cnt_q <= '0;
        end else if (os_tick) begin
            if (bit_cnt_q == BIT_W'(OS_RATE - 1)) begin
                bit_cnt_q <= '0;
            end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
        end
    end

    assign sample = os_tick && (bit_cnt_q == BIT_W'(OS_RATE / 2 - 1));

    always_comb begin
        par_mismatch = 1'b0;
        if (PAR_EN) begin
            par_mismatch = (^shift_q) ^ par_q ^ PAR_ODD;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        dout_d  = dout_q;
        vld_d   = 1'b0;
        fe_d    = 1'b0;
        pe_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (fall_edge) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (sample) begin
                    if (!rxd_s) begin
                        state_d = S_DATA;
                        idx_d   = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (sample) begin
                    shift_d[idx_q] = rxd_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = PAR_EN ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (sample) begin
                    par_d   = rxd_s;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // Leave at the stop-bit midpoint so a back-to-back start edge is not missed.
                if (sample) begin
                    state_d = S_IDLE;
                    dout_d  = shift_q;
                    vld_d   = 1'b1;
                    fe_d    = ~rxd_s;
                    pe_d    = par_mismatch;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            fe_q    <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            fe_q    <= fe_d;
            pe_q    <= pe_d;
        end
    end

    assign DOUT         = dout_q;
    assign DOUT_VLD     = vld_q;
    assign FRAME_ERROR  = fe_q;
    assign PARITY_ERROR = pe_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with no-parity, even and odd instances
module tb_uart_rx;

    localparam int T = 432;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rxd;
    logic [7:0] dout [3];
    logic [2:0] vld;
    logic [2:0] fe;
    logic [2:0] pe;

    logic [9:0] q0[$];
    logic [9:0] q1[$];
    logic [9:0] q2[$];
    int         vld_cyc[$];
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.PARITY_BIT("none")) u_none (
        .CLK(clk), .RST(rst), .UART_RXD(rxd[0]), .DOUT(dout[0]),
        .DOUT_VLD(vld[0]), .FRAME_ERROR(fe[0]), .PARITY_ERROR(pe[0])
    );
    uart_rx #(.PARITY_BIT("even")) u_even (
        .CLK(clk), .RST(rst), .UART_RXD(rxd[1]), .DOUT(dout[1]),
        .DOUT_VLD(vld[1]), .FRAME_ERROR(fe[1]), .PARITY_ERROR(pe[1])
    );
    uart_rx #(.PARITY_BIT("odd")) u_odd (
        .CLK(clk), .RST(rst), .UART_RXD(rxd[2]), .DOUT(dout[2]),
        .DOUT_VLD(vld[2]), .FRAME_ERROR(fe[2]), .PARITY_ERROR(pe[2])
    );

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [7:0] d, input logic f, input logic p);
        case (id)
            0:       q0.push_back({d, f, p});
            1:       q1.push_back({d, f, p});
            default: q2.push_back({d, f, p});
        endcase
    endtask

    task automatic drive(input int id, input logic v, input int n);
        rxd[id] = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int id, input logic [7:0] b, input bit use_par, input logic pbit,
                        input logic stopv, input int bclk, input int sclk);
        drive(id, 1'b0, bclk);
        for (int i = 0; i < 8; i++) drive(id, b[i], bclk);
        if (use_par) drive(id, pbit, bclk);
        drive(id, stopv, sclk);
        rxd[id] = 1'b1;
    endtask

    // Monitor: every DOUT_VLD pops the matching expectation.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (vld[i] === 1'b1) begin
                logic [9:0] got;
                logic [9:0] exp;
                int         sz;
                got = {dout[i], fe[i], pe[i]};
                if (i == 0) vld_cyc.push_back(cyc);
                sz = (i == 0) ? q0.size() : (i == 1) ? q1.size() : q2.size();
                n_tests++;
                if (sz == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_vld dut%0d: got dout/fe/pe %h required no strobe", i, got);
                end else begin
                    exp = (i == 0) ? q0.pop_front() : (i == 1) ? q1.pop_front() : q2.pop_front();
                    if (got !== exp) begin
                        n_fail++;
                        $display("FAIL frame dut%0d: got dout/fe/pe %h required %h", i, got, exp);
                    end
                end
            end
        end
    end

    initial begin
        int base;
        rst = 1'b1;
        rxd = 3'b111;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++) chk("reset_outputs", {dout[i], vld[i], fe[i], pe[i]}, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        push_exp(0, 8'h55, 1'b0, 1'b0);
        send(0, 8'h55, 1'b0, 1'b0, 1'b1, T, T);
        repeat (2 * T) @(negedge clk);

        base = vld_cyc.size();
        push_exp(0, 8'hA5, 1'b0, 1'b0);
        push_exp(0, 8'h3C, 1'b0, 1'b0);
        send(0, 8'hA5, 1'b0, 1'b0, 1'b1, T, T);
        send(0, 8'h3C, 1'b0, 1'b0, 1'b1, T, T);
        repeat (2 * T) @(negedge clk);
        chk("b2b_count", vld_cyc.size() - base, 2);
        if (vld_cyc.size() == base + 2) begin
            int d;
            d = vld_cyc[base + 1] - vld_cyc[base] - 10 * T;
            chk("b2b_spacing_within_tick", (d >= -27 && d <= 27) ? 1 : 0, 1);
        end

        drive(0, 1'b0, 100);
        drive(0, 1'b1, 2 * T);
        push_exp(0, 8'h0F, 1'b0, 1'b0);
        send(0, 8'h0F, 1'b0, 1'b0, 1'b1, T, T);
        repeat (2 * T) @(negedge clk);

        push_exp(0, 8'h81, 1'b1, 1'b0);
        send(0, 8'h81, 1'b0, 1'b0, 1'b0, T, 3 * T);
        repeat (2 * T) @(negedge clk);

        push_exp(1, 8'h07, 1'b0, 1'b1);
        send(1, 8'h07, 1'b1, 1'b0, 1'b1, T, T);
        push_exp(1, 8'h07, 1'b0, 1'b0);
        send(1, 8'h07, 1'b1, 1'b1, 1'b1, T, T);
        push_exp(2, 8'h07, 1'b0, 1'b0);
        send(2, 8'h07, 1'b1, 1'b0, 1'b1, T, T);
        push_exp(2, 8'h07, 1'b0, 1'b1);
        send(2, 8'h07, 1'b1, 1'b1, 1'b1, T, T);
        repeat (2 * T) @(negedge clk);

        drive(0, 1'b0, T);
        drive(0, 1'b1, 3 * T + T / 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) chk("midframe_reset_outputs", {dout[i], vld[i], fe[i], pe[i]}, 0);
        repeat (6 * T) @(negedge clk);

        push_exp(0, 8'hF0, 1'b0, 1'b0);
        send(0, 8'hF0, 1'b0, 1'b0, 1'b1, 419, 419);
        push_exp(0, 8'h0F, 1'b0, 1'b0);
        send(0, 8'h0F, 1'b0, 1'b0, 1'b1, 445, 445);
        repeat (2 * T) @(negedge clk);

        chk("pending_dut0", q0.size(), 0);
        chk("pending_dut1", q1.size(), 0);
        chk("pending_dut2", q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
